// File: rtl/ccff_pkg.sv
// Shared types and sizing helpers for the ccff configuration-chain loader.
package ccff_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        VERIFY = 2'd2,
        DONE   = 2'd3
    } ccff_state_e;

    localparam int DEFAULT_CHAIN_LEN = 16;
    localparam int CNT_W             = $clog2(DEFAULT_CHAIN_LEN + 1);

    // Bit-counter width able to hold the value chain_len itself.
    function automatic int cnt_width(input int chain_len);
        return $clog2(chain_len + 1);
    endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Turns valid/ready bitstream words into one registered serial bit per shift cycle, MSB first.
module ccff_word_serializer #(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              i_active,
    input  logic              i_pass_last,
    input  logic [WORD_W-1:0] i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic              o_head,
    output logic              o_shift_en
);

    localparam int BW = $clog2(WORD_W + 1);

    logic [WORD_W-1:0] r_word;
    logic [BW-1:0]     r_bits_left;
    logic              r_head;
    logic              r_shift_en;
    logic              w_word_end;
    logic              w_pass_end;
    logic              w_take;

    assign w_word_end = (r_bits_left == '0);
    assign w_pass_end = r_shift_en && i_pass_last;
    // A new word may be taken when nothing is presented or the presented bit closes its word.
    assign o_ready    = i_active && !w_pass_end && (!r_shift_en || w_word_end);
    assign w_take     = o_ready && i_valid;

    always_ff @(posedge clk) begin
        if (srst) begin
            r_word      <= '0;
            r_bits_left <= '0;
            r_head      <= 1'b0;
            r_shift_en  <= 1'b0;
        end else if (!i_active || w_pass_end) begin
            // Leftover bits are dropped so the next pass starts on a fresh word.
            r_word      <= '0;
            r_bits_left <= '0;
            r_shift_en  <= 1'b0;
        end else if (w_take) begin
            r_head      <= i_data[WORD_W-1];
            r_word      <= i_data << 1;
            r_bits_left <= BW'(WORD_W - 1);
            r_shift_en  <= 1'b1;
        end else if (r_shift_en && !w_word_end) begin
            r_head      <= r_word[WORD_W-1];
            r_word      <= r_word << 1;
            r_bits_left <= r_bits_left - 1'b1;
            r_shift_en  <= 1'b1;
        end else begin
            r_shift_en  <= 1'b0;
        end
    end

    assign o_head     = r_head;
    assign o_shift_en = r_shift_en;

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Drives ccff_head/ccff_shift_en of a configuration chain from a word stream, with optional read-back verify.
module ccff_bitstream_loader
    import ccff_pkg::*;
#(
    parameter int CHAIN_LEN = 16,
    parameter int WORD_W    = 8,
    parameter int ERR_W     = 16
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              cfg_start,
    input  logic              cfg_verify,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic [ERR_W-1:0]  err_count
);

    localparam int                      PASS_CNT_W = cnt_width(CHAIN_LEN);
    localparam logic [PASS_CNT_W-1:0]   LAST_IDX   = PASS_CNT_W'(CHAIN_LEN - 1);
    localparam logic [PASS_CNT_W-1:0]   FULL_CNT   = PASS_CNT_W'(CHAIN_LEN);

    ccff_state_e             r_state;
    ccff_state_e             w_state_next;
    logic [PASS_CNT_W-1:0]   r_bit_cnt;
    logic [PASS_CNT_W-1:0]   w_bit_cnt_next;
    logic [ERR_W-1:0]        r_err;
    logic [ERR_W-1:0]        w_err_next;
    logic                    r_verify;
    logic                    w_verify_next;
    logic                    r_busy;
    logic                    r_done;
    logic                    w_active;
    logic                    w_pass_last;
    logic                    w_shift_en;
    logic                    w_head;

    assign w_active    = (r_state == LOAD) || (r_state == VERIFY);
    assign w_pass_last = (r_bit_cnt == LAST_IDX);

    ccff_word_serializer #(
        .WORD_W (WORD_W)
    ) u_serializer (
        .clk         (prog_clk),
        .srst        (prog_reset),
        .i_active    (w_active),
        .i_pass_last (w_pass_last),
        .i_data      (s_data),
        .i_valid     (s_valid),
        .o_ready     (s_ready),
        .o_head      (w_head),
        .o_shift_en  (w_shift_en)
    );

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_err     <= '0;
            r_verify  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_err     <= w_err_next;
            r_verify  <= w_verify_next;
            r_busy    <= (w_state_next == LOAD) || (w_state_next == VERIFY);
            r_done    <= (w_state_next == DONE);
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_bit_cnt_next = r_bit_cnt;
        w_err_next     = r_err;
        w_verify_next  = r_verify;
        case (r_state)
            IDLE, DONE: begin
                if (cfg_start) begin
                    w_state_next   = LOAD;
                    w_bit_cnt_next = '0;
                    w_err_next     = '0;
                    w_verify_next  = cfg_verify;
                end
            end
            LOAD: begin
                if (w_shift_en) begin
                    if (w_pass_last) begin
                        w_state_next   = r_verify ? VERIFY : DONE;
                        w_bit_cnt_next = r_verify ? '0 : FULL_CNT;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 1'b1;
                    end
                end
            end
            VERIFY: begin
                if (w_shift_en) begin
                    // Tail now carries bit k of the first pass while head presents bit k again.
                    if ((ccff_tail != w_head) && (r_err != '1)) begin
                        w_err_next = r_err + 1'b1;
                    end
                    if (w_pass_last) begin
                        w_state_next   = DONE;
                        w_bit_cnt_next = FULL_CNT;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 1'b1;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign ccff_head     = w_head;
    assign ccff_shift_en = w_shift_en;
    assign busy          = r_busy;
    assign done          = r_done;
    assign err_count     = r_err;

endmodule
